// File: rtl/avalon_pio_pkg.sv
// Purpose: shared constants for the Avalon-MM output PIO with pulse engine.
//   Register word offsets, bus widths and the STATUS field layout.
// Ports: none (package).
package avalon_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    // Word register offsets
    localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_SET       = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLR       = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_PULSE     = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd6;

    // STATUS layout: busy in bit 0, counter directly above it
    localparam int unsigned STATUS_BUSY_BIT = 0;

    // Avalon write qualifier (active-low write strobe)
    function automatic logic is_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// Purpose: one-shot pulse engine. A trigger with a non-zero length ORs
//   trig_mask into the active mask and (re)loads the down-counter; when the
//   counter expires the mask clears and done strobes for one cycle.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   trigger             write to the PULSE register this cycle
//   trig_mask[DATA_W]   bits to add to the active inversion mask
//   len[CNT_W]          pulse length in cycles (0 = trigger ignored)
//   pulse_mask[DATA_W]  active inversion mask
//   cnt[CNT_W]          remaining pulse cycles
//   busy                cnt != 0
//   done                one-cycle strobe after a pulse completes
module pio_pulse_timer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trigger,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [CNT_W-1:0]  len,
    output logic [DATA_W-1:0] pulse_mask,
    output logic [CNT_W-1:0]  cnt,
    output logic              busy,
    output logic              done
);

    logic [DATA_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;

    // Next-state: a valid trigger beats expiry on the same edge
    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        load   = trigger && (len != '0);

        if (load) begin
            cnt_d  = len;
            mask_d = mask_q | trig_mask;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                mask_d = '0;
                done_d = 1'b1;
            end
        end

        // busy is registered from the next count so it tracks cnt exactly
        busy_d = (cnt_d != '0);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign pulse_mask = mask_q;
    assign cnt        = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: rtl/avalon_pio_out_pulse.sv
// Purpose: Avalon-MM slave output PIO with SET/CLR/TOGGLE aliases and a
//   hardware one-shot pulse engine that inverts selected output bits.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address[3]          word register offset
//   chipselect, write_n Avalon slave select / active-low write strobe
//   writedata[32]       write data (upper unused bits ignored)
//   readdata[32]        zero-latency read data, zero-extended
//   out_port[DATA_W]    data register XOR active pulse mask
//   pulse_done          one-cycle strobe when a pulse completes
//   busy                high while the pulse counter is non-zero
module avalon_pio_out_pulse
    import avalon_pio_pkg::*;
#(
    parameter int unsigned       DATA_W            = 8,
    parameter int unsigned       CNT_W             = 16,
    parameter logic [DATA_W-1:0] RESET_VALUE       = '0,
    parameter logic [CNT_W-1:0]  PULSE_LEN_DEFAULT = CNT_W'(1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              pulse_done,
    output logic              busy
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  len_q,  len_d;
    logic [DATA_W-1:0] wd_data;
    logic [CNT_W-1:0]  wd_cnt;
    logic              wr;
    logic              pulse_trig;
    logic [DATA_W-1:0] pulse_mask;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    status;
    logic              unused_wd;

    assign wr         = is_write(chipselect, write_n);
    assign wd_data    = writedata[DATA_W-1:0];
    assign wd_cnt     = writedata[CNT_W-1:0];
    assign pulse_trig = wr && (address == ADDR_PULSE);
    assign unused_wd  = ^writedata;

    // Register write decode
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (wr) begin
            case (address)
                ADDR_DATA:      data_d = wd_data;
                ADDR_SET:       data_d = data_q | wd_data;
                ADDR_CLR:       data_d = data_q & ~wd_data;
                ADDR_TOGGLE:    data_d = data_q ^ wd_data;
                ADDR_PULSE_LEN: len_d  = wd_cnt;
                default:        ;
            endcase
        end
    end

    // Data and pulse-length registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            len_q  <= PULSE_LEN_DEFAULT;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
        end
    end

    pio_pulse_timer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (pulse_trig),
        .trig_mask  (wd_data),
        .len        (len_q),
        .pulse_mask (pulse_mask),
        .cnt        (cnt),
        .busy       (busy),
        .done       (pulse_done)
    );

    // STATUS word; truncated to the bus when CNT_W fills it
    always_comb begin
        status                  = {cnt, 1'b0};
        status[STATUS_BUSY_BIT] = busy;
    end

    // Zero-latency read mux, independent of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = BUS_W'(data_q);
            ADDR_PULSE_LEN: readdata = BUS_W'(len_q);
            ADDR_PULSE:     readdata = BUS_W'(pulse_mask);
            ADDR_STATUS:    readdata = BUS_W'(status);
            default:        readdata = '0;
        endcase
    end

    // Both operands are reset registers, so reset clears the pulse at once
    assign out_port = data_q ^ pulse_mask;

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Purpose: self-checking bench for avalon_pio_out_pulse (DATA_W=8, CNT_W=16,
//   RESET_VALUE=8'hA5). Reference model tracks pulses by absolute expiry time.
module tb_avalon_pio_out_pulse;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalon_pio_out_pulse #(
        .DATA_W            (8),
        .CNT_W             (16),
        .RESET_VALUE       (8'hA5),
        .PULSE_LEN_DEFAULT (16'd1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_done (pulse_done),
        .busy       (busy)
    );

    // Reference model: pulse ends at absolute edge m_end
    int unsigned t;
    int unsigned m_end;
    logic        m_active;
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    logic [15:0] m_len;
    logic        m_done;

    task automatic model_reset();
        t        = 0;
        m_end    = 0;
        m_active = 1'b0;
        m_data   = 8'hA5;
        m_mask   = 8'h00;
        m_len    = 16'd1;
        m_done   = 1'b0;
    endtask

    task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [31:0] wd);
        logic w;
        t      = t + 1;
        w      = cs && !wn;
        m_done = 1'b0;
        if (w && a == 3'd5 && m_len != 16'd0) begin
            m_end    = t + int'(m_len);
            m_active = 1'b1;
            m_mask   = m_mask | wd[7:0];
        end else if (m_active && t == m_end) begin
            m_active = 1'b0;
            m_mask   = 8'h00;
            m_done   = 1'b1;
        end
        if (w) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: m_data = m_data | wd[7:0];
                3'd2: m_data = m_data & ~wd[7:0];
                3'd3: m_data = m_data ^ wd[7:0];
                3'd4: m_len  = wd[15:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        int unsigned c;
        c = m_active ? (m_end - t) : 0;
        case (a)
            3'd0: return {24'd0, m_data};
            3'd4: return {16'd0, m_len};
            3'd5: return {24'd0, m_mask};
            3'd6: return {15'd0, c[15:0], m_active};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
        end
    endtask

    // One clock: drive, edge, update model, sample 1ns later and compare
    task automatic do_cycle(input logic cs, input logic wn, input logic [2:0] a,
                            input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_edge(cs, wn, a, wd);
        #1;
        check("out_port", {24'd0, out_port}, {24'd0, m_data ^ m_mask});
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("pulse_done", {31'd0, pulse_done}, {31'd0, m_done});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        do_cycle(1'b1, 1'b0, a, wd);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    // Combinational read, no clock edge
    task automatic peek(input string name, input logic [2:0] a, input logic [31:0] exp);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = a;
        #1;
        check(name, readdata, exp);
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int dones;

        vecs[0] = '{3'd0, 32'h0000_01FF, 8'hFF, 32'h0000_00FF};
        vecs[1] = '{3'd0, 32'hDEAD_BE0F, 8'h0F, 32'h0000_000F};
        vecs[2] = '{3'd1, 32'h0000_0030, 8'h3F, 32'h0000_0000};
        vecs[3] = '{3'd2, 32'h0000_0003, 8'h3C, 32'h0000_0000};
        vecs[4] = '{3'd3, 32'h0000_00FF, 8'hC3, 32'h0000_0000};
        vecs[5] = '{3'd7, 32'hFFFF_FFFF, 8'hC3, 32'h0000_0000};
        vecs[6] = '{3'd6, 32'hFFFF_FFFF, 8'hC3, 32'h0000_0000};
        vecs[7] = '{3'd4, 32'hABC1_2345, 8'hC3, 32'h0000_2345};
        vecs[8] = '{3'd4, 32'h0000_0001, 8'hC3, 32'h0000_0001};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        check("rst_out_port", {24'd0, out_port}, 32'h0000_00A5);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, pulse_done}, 32'd0);
        peek("rst_status", 3'd6, 32'd0);
        peek("rst_data", 3'd0, 32'h0000_00A5);
        peek("rst_len", 3'd4, 32'd1);

        // Table-driven register writes and readbacks
        for (int i = 0; i < 9; i++) begin
            wr_reg(vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d_out", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
            peek($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
        end

        // Basic pulse: 3 cycles high, done one cycle after the last
        begin
            logic [7:0] e_out[5];
            logic       e_busy[5];
            logic       e_done[5];
            e_out  = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
            e_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            e_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            wr_reg(3'd0, 32'd0);
            wr_reg(3'd4, 32'd3);
            for (int i = 0; i < 5; i++) begin
                if (i == 0) wr_reg(3'd5, 32'h01);
                else        idle();
                check($sformatf("p3_out%0d", i), {24'd0, out_port}, {24'd0, e_out[i]});
                check($sformatf("p3_busy%0d", i), {31'd0, busy}, {31'd0, e_busy[i]});
                check($sformatf("p3_done%0d", i), {31'd0, pulse_done}, {31'd0, e_done[i]});
            end
        end

        // Retrigger while busy: single done, mask ORed, full reload
        wr_reg(3'd4, 32'd4);
        dones = 0;
        wr_reg(3'd5, 32'h01);
        idle();
        wr_reg(3'd5, 32'h02);
        check("rt_out0", {24'd0, out_port}, 32'h03);
        peek("rt_status", 3'd6, 32'h9);
        for (int i = 1; i < 4; i++) begin
            idle();
            check($sformatf("rt_out%0d", i), {24'd0, out_port}, 32'h03);
            dones += int'(pulse_done);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            dones += int'(pulse_done);
        end
        check("rt_out_end", {24'd0, out_port}, 32'h00);
        check("rt_done_count", 32'(dones), 32'd1);

        // Zero pulse length: trigger ignored
        wr_reg(3'd4, 32'd0);
        wr_reg(3'd5, 32'hFF);
        check("len0_out", {24'd0, out_port}, 32'h00);
        check("len0_busy", {31'd0, busy}, 32'd0);
        peek("len0_mask", 3'd5, 32'd0);
        idle();

        // Trigger on the expiry edge wins
        wr_reg(3'd4, 32'd2);
        wr_reg(3'd5, 32'h01);
        idle();
        wr_reg(3'd5, 32'h04);
        check("exp_out", {24'd0, out_port}, 32'h05);
        check("exp_done", {31'd0, pulse_done}, 32'd0);
        peek("exp_status", 3'd6, 32'h5);
        peek("exp_mask", 3'd5, 32'h5);
        idle();
        check("exp_out2", {24'd0, out_port}, 32'h05);
        idle();
        check("exp_out3", {24'd0, out_port}, 32'h00);
        check("exp_done3", {31'd0, pulse_done}, 32'd1);

        // Reset mid-pulse
        wr_reg(3'd4, 32'd10);
        wr_reg(3'd5, 32'hFF);
        idle();
        chipselect = 1'b0;
        reset_n    = 1'b0;
        #1;
        check("mrst_out", {24'd0, out_port}, 32'h0000_00A5);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, pulse_done}, 32'd0);
        @(posedge clk);
        #1;
        check("mrst_done2", {31'd0, pulse_done}, 32'd0);
        reset_n = 1'b1;
        model_reset();
        peek("mrst_len", 3'd4, 32'd1);
        peek("mrst_status", 3'd6, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic        cs;
            logic        wn;
            logic [2:0]  a;
            logic [31:0] wd;
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 2) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
            if (a == 3'd4)
                wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            else if ($urandom_range(0, 1) == 0)
                wd = $urandom & 32'h0000_0003;
            else
                wd = $urandom;
            do_cycle(cs, wn, a, wd);
            begin
                logic [2:0] ra;
                ra = 3'($urandom_range(0, 7));
                peek("rand_rd", ra, model_read(ra));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
